// File: rtl/prom_loader_pkg.sv
// prom_loader shared types.
// Frame-parser states and the default frame marker.
package prom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LOW,
    S_HIGH,
    S_CHECK
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/prom_loader_byte_timeout.sv
// Inter-byte timeout for prom_loader.
// Reloads on clear and counts down while enabled.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Zero means this is the last idle cycle allowed.
  assign expired_o = enable_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/prom_loader.sv
// Framed UART-to-PROM loader.
// Checks sync/length/checksum and writes 16-bit LE words.
module prom_loader
  import prom_loader_pkg::*;
#(
  parameter int          ROM_WORDS      = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_ready_i,
  output logic                         rx_ack_o,
  output logic                         prom_we_o,
  output logic [$clog2(ROM_WORDS)-1:0] prom_addr_o,
  output logic [15:0]                  prom_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int AW = $clog2(ROM_WORDS);
  localparam logic [8:0] MAXN = 9'(ROM_WORDS);

  state_t        state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    lo_q, lo_d;
  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [15:0]   wdata_d;
  logic          done_d, error_d;
  logic          expired;
  logic          to_clear;
  logic          last_word;

  assign rx_ack_o  = rx_ready_i;
  assign busy_o    = (state_q != S_IDLE);
  assign to_clear  = rx_ready_i || (state_q == S_IDLE);
  assign last_word = (8'(addr_q) == (n_q - 8'd1));

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (to_clear),
    .enable_i (busy_o),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    waddr_d = prom_addr_o;
    wdata_d = prom_data_o;
    done_d  = done_o;
    error_d = error_o;
    unique case (state_q)
      S_IDLE: begin
        if (rx_ready_i && (rx_data_i == SYNC_BYTE)) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          sum_d   = 8'd0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_ready_i) begin
          if ((rx_data_i == 8'd0) ||
              ({1'b0, rx_data_i} > MAXN)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d     = rx_data_i;
            sum_d   = rx_data_i;
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (rx_ready_i) begin
          lo_d    = rx_data_i;
          sum_d   = sum_q + rx_data_i;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (rx_ready_i) begin
          sum_d   = sum_q + rx_data_i;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {rx_data_i, lo_q};
          if (last_word) begin
            state_d = S_CHECK;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_LOW;
          end
        end
      end
      S_CHECK: begin
        if (rx_ready_i) begin
          if (rx_data_i == sum_q) done_d = 1'b1;
          else                    error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // An arriving byte always beats an expiring count.
    if (expired && !rx_ready_i) begin
      error_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      n_q         <= 8'd0;
      addr_q      <= '0;
      sum_q       <= 8'd0;
      lo_q        <= 8'd0;
      prom_we_o   <= 1'b0;
      prom_addr_o <= '0;
      prom_data_o <= 16'd0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      prom_we_o   <= we_d;
      prom_addr_o <= waddr_d;
      prom_data_o <= wdata_d;
      done_o      <= done_d;
      error_o     <= error_d;
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader.
// Frame table plus timeout and reset sequences.
module tb_prom_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ack;
  logic        prom_we;
  logic [3:0]  prom_addr;
  logic [15:0] prom_data;
  logic        busy;
  logic        done;
  logic        error;

  int tests;
  int fails;

  logic [19:0] wq[$];

  prom_loader #(
    .ROM_WORDS(16),
    .TIMEOUT_CYCLES(255),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data_i  (rx_data),
    .rx_ready_i (rx_ready),
    .rx_ack_o   (rx_ack),
    .prom_we_o  (prom_we),
    .prom_addr_o(prom_addr),
    .prom_data_o(prom_data),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prom_we) wq.push_back({prom_addr, prom_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, limit 2ms");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          len;
    logic [7:0]  b [8];
    int          nw;
    logic [3:0]  wa [2];
    logic [15:0] wd [2];
    logic        dn;
    logic        er;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    chk("ack", 32'(rx_ack), 32'd1);
  endtask

  task automatic idle(input int n);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;

    v[0] = '{5, '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h47, 8'h0, 8'h0, 8'h0},
             1, '{4'd0, 4'd0}, '{16'h1234, 16'h0}, 1'b1, 1'b0};
    v[1] = '{7, '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC, 8'h0},
             2, '{4'd0, 4'd1}, '{16'h2211, 16'h4433}, 1'b1, 1'b0};
    v[2] = '{5, '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h48, 8'h0, 8'h0, 8'h0},
             1, '{4'd0, 4'd0}, '{16'h1234, 16'h0}, 1'b0, 1'b1};
    v[3] = '{2, '{8'hA5, 8'h11, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
             0, '{4'd0, 4'd0}, '{16'h0, 16'h0}, 1'b0, 1'b1};
    v[4] = '{2, '{8'hA5, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
             0, '{4'd0, 4'd0}, '{16'h0, 16'h0}, 1'b0, 1'b1};
    v[5] = '{7, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h34, 8'h12, 8'h47, 8'h0},
             1, '{4'd0, 4'd0}, '{16'h1234, 16'h0}, 1'b1, 1'b0};
    v[6] = '{5, '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h4B, 8'h0, 8'h0, 8'h0},
             1, '{4'd0, 4'd0}, '{16'hA5A5, 16'h0}, 1'b1, 1'b0};
    v[7] = '{5, '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h0, 8'h0, 8'h0},
             1, '{4'd0, 4'd0}, '{16'hFFFF, 16'h0}, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(prom_we), 32'd0);
    chk("rst_addr", 32'(prom_addr), 32'd0);
    chk("rst_data", 32'(prom_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      wq.delete();
      for (int k = 0; k < v[i].len; k++) send(v[i].b[k]);
      idle(3);
      chk($sformatf("v%0d_nw", i), 32'(wq.size()), 32'(v[i].nw));
      for (int w = 0; w < v[i].nw; w++) begin
        if (w < wq.size()) begin
          chk($sformatf("v%0d_w%0d", i, w), 32'(wq[w]),
              32'({v[i].wa[w], v[i].wd[w]}));
        end
      end
      chk($sformatf("v%0d_done", i), 32'(done), 32'(v[i].dn));
      chk($sformatf("v%0d_err", i), 32'(error), 32'(v[i].er));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    end

    // Busy tracks the frame; silence after byte 3 times out.
    wq.delete();
    send(8'hA5);
    chk("busy_rise", 32'(busy), 32'd1);
    chk("sync_clr_done", 32'(done), 32'd0);
    send(8'h01);
    send(8'h34);
    idle(254);
    chk("to_early_err", 32'(error), 32'd0);
    chk("to_early_busy", 32'(busy), 32'd1);
    idle(1);
    chk("to_err", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_nw", 32'(wq.size()), 32'd0);
    for (int k = 0; k < 5; k++) send(v[0].b[k]);
    idle(2);
    chk("to_rec_done", 32'(done), 32'd1);
    chk("to_rec_err", 32'(error), 32'd0);

    // Byte landing exactly in the expiry cycle wins.
    wq.delete();
    send(8'hA5);
    send(8'h01);
    send(8'h34);
    idle(254);
    send(8'h12);
    send(8'h47);
    idle(2);
    chk("edge_err", 32'(error), 32'd0);
    chk("edge_done", 32'(done), 32'd1);
    chk("edge_nw", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("edge_w", 32'(wq[0]), 32'h0_1234);

    // Asynchronous reset in the middle of a frame.
    send(8'hA5);
    send(8'h01);
    send(8'h34);
    rx_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_data", 32'(prom_data), 32'd0);
    chk("ar_addr", 32'(prom_addr), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(error), 32'd0);
    chk("ar_we", 32'(prom_we), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    wq.delete();
    for (int k = 0; k < 7; k++) send(v[1].b[k]);
    idle(2);
    chk("ar_rec_nw", 32'(wq.size()), 32'd2);
    chk("ar_rec_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
